// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared types, constants and helpers for the CIC decimator sequencing
// controller (cic_decim_ctrl and its cic_rate_counter sub-block).
//   cic_state_e  : controller state (IDLE, WARMUP, RUN)
//   CIC_RATE_W   : default width of the decimation-rate field
//   MIN_RATE     : smallest legal decimation rate
//   clamp_rate() : maps a requested rate of 0 onto MIN_RATE
// -----------------------------------------------------------------------------
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } cic_state_e;

    localparam int CIC_RATE_W = 16;
    localparam int MIN_RATE   = 1;

    // Works on a 32-bit container so callers of any rate width up to 32 bits
    // can share it; callers cast back to their own width.
    function automatic logic [31:0] clamp_rate(input logic [31:0] rate);
        return (rate < 32'(MIN_RATE)) ? 32'(MIN_RATE) : rate;
    endfunction

endpackage

// File: rtl/cic_rate_counter.sv
// -----------------------------------------------------------------------------
// cic_rate_counter
// Input-rate phase counter for the CIC decimator. Counts integrator enables,
// flags the decimation boundary (phase == rate - 1 with a step) and applies a
// pending rate change exactly at that boundary. While the controller is idle
// the phase is held at 0 and rate changes take effect immediately.
//
// Ports:
//   clk_i         in   clock
//   reset_i       in   asynchronous active-high reset
//   idle_i        in   controller is in IDLE
//   step_i        in   integrator enable (one input sample consumed)
//   rate_i        in   requested rate (0 is clamped to 1)
//   rate_load_i   in   strobe: capture rate_i as the pending rate
//   wrap_o        out  decimation boundary this cycle (combinational)
//   rate_apply_o  out  pending rate is applied at this boundary
//   rate_o        out  rate currently in effect
// -----------------------------------------------------------------------------
module cic_rate_counter
    import cic_pkg::*;
#(
    parameter int RATE_W       = CIC_RATE_W,
    parameter int DEFAULT_RATE = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              idle_i,
    input  logic              step_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              rate_load_i,
    output logic              wrap_o,
    output logic              rate_apply_o,
    output logic [RATE_W-1:0] rate_o
);

    localparam logic [RATE_W-1:0] RESET_RATE = RATE_W'(clamp_rate(32'(DEFAULT_RATE)));

    logic [RATE_W-1:0] phase_q, phase_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [RATE_W-1:0] rate_in_clamped;

    assign rate_in_clamped = RATE_W'(clamp_rate(32'(rate_i)));

    // rate_q is never below 1, so rate_q - 1 cannot underflow. The >= guards
    // against a phase left beyond the boundary, which the update rules never
    // produce but would otherwise stall the decimator.
    assign wrap_o = step_i && !idle_i && (phase_q >= (rate_q - RATE_W'(1)));

    always_comb begin
        phase_d      = phase_q;
        rate_d       = rate_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        rate_apply_o = 1'b0;

        if (idle_i) begin
            phase_d = '0;
            // No boundary to wait for while idle: take the newest request.
            if (rate_load_i) begin
                rate_d     = rate_in_clamped;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                rate_d     = pend_q;
                pend_vld_d = 1'b0;
            end
        end else begin
            if (wrap_o) begin
                phase_d = '0;
                if (pend_vld_q) begin
                    rate_d       = pend_q;
                    pend_vld_d   = 1'b0;
                    rate_apply_o = 1'b1;
                end
            end else if (step_i) begin
                phase_d = phase_q + RATE_W'(1);
            end
            // A strobe on the boundary cycle becomes the next pending request.
            if (rate_load_i) begin
                pend_d     = rate_in_clamped;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q    <= '0;
            rate_q     <= RESET_RATE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            rate_q     <= rate_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign rate_o = rate_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
// Sequencing controller for a CIC decimator whose integrator and comb stages
// carry clock enables. Produces the integrator enable (input rate), the comb
// enable (decimated rate), suppresses outputs while the comb chain refills
// after start-up or a rate change, and qualifies outputs with a valid/ready
// handshake plus sticky overrun detection.
//
// Optional feature macro: CIC_CTRL_STATS_EN adds saturating counters
// out_count_o (accepted outputs) and drop_count_o (overrun events).
//
// Ports:
//   clk_i         in   clock
//   reset_i       in   asynchronous active-high reset
//   enable_i      in   run request; low returns to IDLE
//   in_valid_i    in   input sample present this cycle
//   rate_i        in   requested decimation rate
//   rate_load_i   in   strobe capturing rate_i as pending rate
//   out_ready_i   in   downstream accepts the decimated sample
//   clear_i       in   clears sticky overrun (and statistics)
//   integ_en_o    out  integrator clock enable
//   comb_en_o     out  comb clock enable (one cycle per decimated sample)
//   out_valid_o   out  comb output holds a valid sample
//   overrun_o     out  sticky: an output was replaced before acceptance
//   busy_o        out  state is WARMUP or RUN
//   rate_o        out  rate currently in effect
//   out_count_o   out  [CIC_CTRL_STATS_EN] accepted outputs
//   drop_count_o  out  [CIC_CTRL_STATS_EN] overrun events
// -----------------------------------------------------------------------------
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int RATE_W       = CIC_RATE_W,
    parameter int N_STAGES     = 4,
    parameter int DEFAULT_RATE = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              in_valid_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              rate_load_i,
    input  logic              out_ready_i,
    input  logic              clear_i,
    output logic              integ_en_o,
    output logic              comb_en_o,
    output logic              out_valid_o,
    output logic              overrun_o,
    output logic              busy_o,
    output logic [RATE_W-1:0] rate_o
`ifdef CIC_CTRL_STATS_EN
    ,
    output logic [31:0]       out_count_o,
    output logic [15:0]       drop_count_o
`endif
);

    localparam int              WARM_W    = $clog2(N_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(N_STAGES - 1);
    localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(N_STAGES);

    cic_state_e        state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              comb_en_q, comb_en_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    logic              in_idle;
    logic              integ_en;
    logic              wrap;
    logic              rate_apply;
    logic              set_valid;
    logic              ovr_event;

    assign in_idle  = (state_q == ST_IDLE);
    assign integ_en = in_valid_i && !in_idle;

    cic_rate_counter #(
        .RATE_W       (RATE_W),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) u_rate_counter (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .idle_i       (in_idle),
        .step_i       (integ_en),
        .rate_i       (rate_i),
        .rate_load_i  (rate_load_i),
        .wrap_o       (wrap),
        .rate_apply_o (rate_apply),
        .rate_o       (rate_o)
    );

    // The comb stages update on comb_en_q, so a pulse seen in RUN means the
    // comb output carries a fresh sample from the following cycle on.
    assign set_valid = comb_en_q && (state_q == ST_RUN);
    assign ovr_event = set_valid && out_valid_q && !out_ready_i;

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        comb_en_d   = wrap && enable_i;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_WARMUP;
            ST_WARMUP: if (comb_en_q && (warm_q == WARM_LAST)) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase

        if (comb_en_q && (state_q == ST_WARMUP) && (warm_q < WARM_MAX)) begin
            warm_d = warm_q + WARM_W'(1);
        end

        // New rate: the comb history mixes two rates, so refill it.
        if (rate_apply) begin
            state_d = ST_WARMUP;
            warm_d  = '0;
        end

        // Set wins over a coincident accept.
        if (set_valid) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // A new overrun wins over a coincident clear.
        if (ovr_event) begin
            overrun_d = 1'b1;
        end else if (clear_i) begin
            overrun_d = 1'b0;
        end

        if (!enable_i) begin
            state_d     = ST_IDLE;
            warm_d      = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            warm_q      <= '0;
            comb_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            comb_en_q   <= comb_en_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign integ_en_o  = integ_en;
    assign comb_en_o   = comb_en_q;
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = !in_idle;

`ifdef CIC_CTRL_STATS_EN
    logic [31:0] out_count_q, out_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        out_count_d  = out_count_q;
        drop_count_d = drop_count_q;
        if (clear_i) begin
            out_count_d  = '0;
            drop_count_d = '0;
        end else if (!in_idle) begin
            if (out_valid_q && out_ready_i && (out_count_q != '1)) begin
                out_count_d = out_count_q + 32'd1;
            end
            if (ovr_event && (drop_count_q != '1)) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            out_count_q  <= out_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_count_o  = out_count_q;
    assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
// Directed self-checking bench for cic_decim_ctrl. Inputs are driven 1 time
// unit after a rising edge and outputs are sampled at that same point, so the
// value seen at "cycle c" is the result of the c-th edge after a test starts.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

    localparam int RATE_W       = 16;
    localparam int N_STAGES     = 4;
    localparam int DEFAULT_RATE = 8;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic              in_valid_i;
    logic [RATE_W-1:0] rate_i;
    logic              rate_load_i;
    logic              out_ready_i;
    logic              clear_i;
    logic              integ_en_o;
    logic              comb_en_o;
    logic              out_valid_o;
    logic              overrun_o;
    logic              busy_o;
    logic [RATE_W-1:0] rate_o;
`ifdef CIC_CTRL_STATS_EN
    logic [31:0]       out_count_o;
    logic [15:0]       drop_count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cic_decim_ctrl #(
        .RATE_W       (RATE_W),
        .N_STAGES     (N_STAGES),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .in_valid_i   (in_valid_i),
        .rate_i       (rate_i),
        .rate_load_i  (rate_load_i),
        .out_ready_i  (out_ready_i),
        .clear_i      (clear_i),
        .integ_en_o   (integ_en_o),
        .comb_en_o    (comb_en_o),
        .out_valid_o  (out_valid_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o),
        .rate_o       (rate_o)
`ifdef CIC_CTRL_STATS_EN
        ,
        .out_count_o  (out_count_o),
        .drop_count_o (drop_count_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Leave RUN/WARMUP, then load a rate while idle (applied immediately).
    task automatic go_idle(input logic [RATE_W-1:0] r);
        enable_i    = 1'b0;
        in_valid_i  = 1'b0;
        clear_i     = 1'b0;
        rate_load_i = 1'b0;
        tick();
        rate_i      = r;
        rate_load_i = 1'b1;
        tick();
        rate_load_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i     = 1'b1;
        enable_i    = 1'b0;
        in_valid_i  = 1'b0;
        rate_i      = '0;
        rate_load_i = 1'b0;
        out_ready_i = 1'b0;
        clear_i     = 1'b0;
        tick();
        tick();
        checks += 6;
        if (integ_en_o !== 1'b0) begin errors++; $display("FAIL reset_integ_en got=%b exp=0", integ_en_o); end
        if (comb_en_o !== 1'b0) begin errors++; $display("FAIL reset_comb_en got=%b exp=0", comb_en_o); end
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (rate_o !== 16'd8) begin errors++; $display("FAIL reset_rate got=%0d exp=8", rate_o); end
        reset_i = 1'b0;
        tick();
        checks += 2;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", busy_o); end
        if (rate_o !== 16'd8) begin errors++; $display("FAIL reset_release_rate got=%0d exp=8", rate_o); end
        $display("test_reset: done");
    endtask

    // Rate 8, continuous input: pulses at 9,17,25,33,41; first output at 42.
    task automatic test_basic();
        logic exp_comb;
        logic exp_valid;
        for (int c = 1; c <= 45; c++) begin
            enable_i    = 1'b1;
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            tick();
            exp_comb  = (c >= 9) && (((c - 9) % 8) == 0);
            exp_valid = (c == 42);
            checks += 4;
            if (comb_en_o !== exp_comb) begin errors++; $display("FAIL basic_comb_en c=%0d got=%b exp=%b", c, comb_en_o, exp_comb); end
            if (out_valid_o !== exp_valid) begin errors++; $display("FAIL basic_out_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
            if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy c=%0d got=%b exp=1", c, busy_o); end
            if (overrun_o !== 1'b0) begin errors++; $display("FAIL basic_overrun c=%0d got=%b exp=0", c, overrun_o); end
            if (out_valid_o === 1'b1) $display("basic: output at cycle %0d rate=%0d", c, rate_o);
        end
    endtask

    // Rate 3 with input every other cycle: pulses every 6 cycles from 6,
    // outputs one cycle wide from 31.
    task automatic test_throughput();
        logic exp_comb;
        logic exp_valid;
        go_idle(16'd3);
        checks++;
        if (rate_o !== 16'd3) begin errors++; $display("FAIL thr_rate_load got=%0d exp=3", rate_o); end
        for (int c = 1; c <= 44; c++) begin
            enable_i    = 1'b1;
            in_valid_i  = ((c % 2) == 0);
            out_ready_i = 1'b1;
            tick();
            exp_comb  = ((c % 6) == 0);
            exp_valid = (c >= 31) && (((c - 31) % 6) == 0);
            checks += 3;
            if (comb_en_o !== exp_comb) begin errors++; $display("FAIL thr_comb_en c=%0d got=%b exp=%b", c, comb_en_o, exp_comb); end
            if (out_valid_o !== exp_valid) begin errors++; $display("FAIL thr_out_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
            if (overrun_o !== 1'b0) begin errors++; $display("FAIL thr_overrun c=%0d got=%b exp=0", c, overrun_o); end
            if (out_valid_o === 1'b1) $display("throughput: output at cycle %0d rate=%0d", c, rate_o);
        end
    endtask

    // Rate 8 to RUN, load 4 at phase 2 (cycle 44); applied at the wrap of
    // cycle 49, then four warm-up pulses (49,53,57,61) and outputs from 66.
    task automatic test_rate_change();
        logic              exp_comb;
        logic              exp_valid;
        logic [RATE_W-1:0] exp_rate;
        go_idle(16'd8);
        for (int c = 1; c <= 76; c++) begin
            enable_i    = 1'b1;
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            rate_i      = 16'd4;
            rate_load_i = (c == 44);
            tick();
            if (c <= 49) exp_comb = (c >= 9) && (((c - 9) % 8) == 0);
            else         exp_comb = (((c - 49) % 4) == 0);
            exp_valid = (c == 42) || ((c >= 66) && (((c - 66) % 4) == 0));
            exp_rate  = (c < 49) ? 16'd8 : 16'd4;
            checks += 4;
            if (comb_en_o !== exp_comb) begin errors++; $display("FAIL rc_comb_en c=%0d got=%b exp=%b", c, comb_en_o, exp_comb); end
            if (out_valid_o !== exp_valid) begin errors++; $display("FAIL rc_out_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
            if (rate_o !== exp_rate) begin errors++; $display("FAIL rc_rate c=%0d got=%0d exp=%0d", c, rate_o, exp_rate); end
            if (busy_o !== 1'b1) begin errors++; $display("FAIL rc_busy c=%0d got=%b exp=1", c, busy_o); end
            if (out_valid_o === 1'b1) $display("rate_change: output at cycle %0d rate=%0d", c, rate_o);
        end
        rate_load_i = 1'b0;
    endtask

    // Rate 0 clamps to 1: comb pulse follows every valid input.
    task automatic test_rate_zero();
        logic v;
        logic exp_comb;
        logic exp_valid;
        go_idle(16'd0);
        checks++;
        if (rate_o !== 16'd1) begin errors++; $display("FAIL zero_rate_clamp got=%0d exp=1", rate_o); end
        for (int c = 1; c <= 10; c++) begin
            v           = ((c % 3) != 0);
            enable_i    = 1'b1;
            in_valid_i  = v;
            out_ready_i = 1'b1;
            tick();
            exp_comb  = (c >= 2) && v;
            exp_valid = (c == 9);
            checks += 3;
            if (integ_en_o !== v) begin errors++; $display("FAIL zero_integ_en c=%0d got=%b exp=%b", c, integ_en_o, v); end
            if (comb_en_o !== exp_comb) begin errors++; $display("FAIL zero_comb_en c=%0d got=%b exp=%b", c, comb_en_o, exp_comb); end
            if (out_valid_o !== exp_valid) begin errors++; $display("FAIL zero_out_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
            if (out_valid_o === 1'b1) $display("rate_zero: output at cycle %0d rate=%0d", c, rate_o);
        end
    endtask

    // Rate 1, out_ready low: overrun at 8, sticky; clear at 11 wins;
    // clear at 13 loses to a coincident overrun; accept at 15.
    task automatic test_overrun();
        logic exp_ovr;
        logic exp_valid;
        go_idle(16'd1);
        for (int c = 1; c <= 15; c++) begin
            enable_i    = 1'b1;
            in_valid_i  = (c <= 8) || (c == 12);
            clear_i     = (c >= 11) && (c <= 13);
            out_ready_i = (c == 15);
            tick();
            exp_ovr   = (c >= 8) && (c != 11) && (c != 12);
            exp_valid = (c >= 7) && (c <= 14);
            checks += 2;
            if (overrun_o !== exp_ovr) begin errors++; $display("FAIL ovr_overrun c=%0d got=%b exp=%b", c, overrun_o, exp_ovr); end
            if (out_valid_o !== exp_valid) begin errors++; $display("FAIL ovr_out_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
        end
        clear_i = 1'b0;
        $display("test_overrun: done");
    endtask

    // Reset mid-RUN with a pending rate of 2; afterwards rate 8 must remain.
    task automatic test_reset_mid_run();
        logic exp_comb;
        go_idle(16'd8);
        for (int c = 1; c <= 46; c++) begin
            enable_i    = 1'b1;
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            rate_i      = 16'd2;
            rate_load_i = (c == 45);
            tick();
        end
        rate_load_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy_o); end
`ifdef CIC_CTRL_STATS_EN
        checks++;
        if (out_count_o === 32'd0) begin errors++; $display("FAIL mid_out_count_before got=%0d exp=nonzero", out_count_o); end
`endif
        reset_i = 1'b1;
        #1;
        checks += 5;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy_o); end
        if (integ_en_o !== 1'b0) begin errors++; $display("FAIL mid_reset_integ_en got=%b exp=0", integ_en_o); end
        if (comb_en_o !== 1'b0) begin errors++; $display("FAIL mid_reset_comb_en got=%b exp=0", comb_en_o); end
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got=%b exp=0", out_valid_o); end
        if (rate_o !== 16'd8) begin errors++; $display("FAIL mid_reset_rate got=%0d exp=8", rate_o); end
`ifdef CIC_CTRL_STATS_EN
        checks += 2;
        if (out_count_o !== 32'd0) begin errors++; $display("FAIL mid_reset_out_count got=%0d exp=0", out_count_o); end
        if (drop_count_o !== 16'd0) begin errors++; $display("FAIL mid_reset_drop_count got=%0d exp=0", drop_count_o); end
`endif
        enable_i   = 1'b0;
        in_valid_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        tick();
        checks++;
        if (rate_o !== 16'd8) begin errors++; $display("FAIL mid_pending_dropped got=%0d exp=8", rate_o); end
        for (int c = 1; c <= 17; c++) begin
            enable_i   = 1'b1;
            in_valid_i = 1'b1;
            tick();
            exp_comb = (c == 9) || (c == 17);
            checks++;
            if (comb_en_o !== exp_comb) begin errors++; $display("FAIL mid_after_comb_en c=%0d got=%b exp=%b", c, comb_en_o, exp_comb); end
        end
        $display("test_reset_mid_run: done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throughput();
        test_rate_change();
        test_rate_zero();
        test_overrun();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencing controller for a CIC decimator built from integrator and comb stages that each carry a clock-enable input. It generates the integrator enable (input rate) and the comb enable (decimated rate). It handles runtime decimation-rate changes and suppresses outputs while the comb chain refills. It also provides a valid/ready-style output qualifier with overrun detection for the downstream consumer.

Parameters:
RATE_W, 16, width of decimation-rate field
N_STAGES, 4, number of comb stages; sets warm-up length
DEFAULT_RATE, 8, decimation rate loaded at reset (must be ≥1)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
enable_i  in  1  run request; low returns controller to IDLE
in_valid_i  in  1  new input sample present this cycle
rate_i  in  RATE_W  requested decimation rate
rate_load_i  in  1  one-cycle strobe capturing rate_i as pending rate
out_ready_i  in  1  downstream accepts decimated sample
clear_i  in  1  clears sticky overrun flag
integ_en_o  out  1  clock enable for integrator stages
comb_en_o  out  1  clock enable for comb stages
out_valid_o  out  1  decimated sample on comb output is valid
overrun_o  out  1  sticky: output replaced before acceptance
busy_o  out  1  state is WARMUP or RUN
rate_o  out  RATE_W  rate currently in effect

Behaviour:
- Reset is asynchronous and active-high on reset_i; clock is clk_i.
- Reset values: all outputs 0 except rate_o = DEFAULT_RATE. Internal phase counter, warm counter and pending-rate valid are cleared; state = IDLE.
- States and transitions:
  - IDLE → WARMUP when enable_i = 1.
  - WARMUP → RUN after N_STAGES comb_en_o pulses.
  - Any state → IDLE when enable_i = 0. On entry to IDLE, phase, warm count and out_valid_o clear; rate_o is retained.
- integ_en_o: combinational, in_valid_i AND (state ≠ IDLE).
- Phase counter: increments on each integ_en_o. At phase == rate_o − 1 with integ_en_o, it wraps to 0 and comb_en_o is registered high for exactly one cycle (latency 1 from the boundary sample).
- Warm counter: counts comb_en_o pulses in WARMUP and saturates at N_STAGES.
- out_valid_o:
  - Set in the cycle after a comb_en_o pulse that occurs in RUN. The comb registers update on that enable, so data is valid then.
  - Cleared when out_valid_o AND out_ready_i.
  - Set and clear in the same cycle: set wins.
- Overrun: a new set while out_valid_o = 1 and out_ready_i = 0 sets overrun_o. overrun_o holds until clear_i or IDLE. clear_i coincident with a new overrun: overrun wins.
- Rate change:
  - rate_load_i captures rate_i into a pending register; a later strobe overwrites it.
  - The pending rate is applied only at a decimation boundary (the same cycle the phase wraps). On application, rate_o updates, the warm counter resets, and state returns to WARMUP.
  - In IDLE, the pending rate is applied immediately.
- rate_i = 0 is clamped to 1. Rate 1 gives comb_en_o every valid input.
- Gaps in in_valid_i stall the phase counter; no enable is generated without input.
- Reset mid-operation drops any pending rate.

Optional Feature:
CIC_CTRL_STATS_EN
- Defined: adds out_count_o [31:0] (accepted outputs, out_valid_o AND out_ready_i) and drop_count_o [15:0] (overrun events). Both saturate, clear on reset or clear_i, and hold in IDLE.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cic_pkg:
  - state enum (IDLE, WARMUP, RUN)
  - RATE_W default
  - MIN_RATE = 1
  - the rate-clamp function
- Sub-module cic_rate_counter:
  - phase counter with wrap pulse and boundary-aligned pending-rate load
  - instantiated once
- FSM, warm counter and output handshake stay in the top module.

Test Plan:
1. Reset, enable_i = 1, in_valid_i continuous, rate 8, N_STAGES = 4 → comb_en_o pulses every 8 cycles; first out_valid_o follows the 5th comb_en_o pulse; busy_o = 1.
2. out_ready_i tied 1, rate 3, in_valid_i toggling 1/0 → comb_en_o every 6 cycles; out_valid_o high exactly 1 cycle per output; overrun_o stays 0.
3. In RUN, rate_load_i with rate_i = 4 mid-phase (phase = 2 of 8) → rate_o changes only at the next wrap; state returns to WARMUP; 4 suppressed comb pulses follow, then outputs every 4 inputs.
4. out_ready_i held 0 across two decimated outputs → overrun_o = 1 and sticky; clear_i pulse → 0; clear_i coincident with a new overrun → stays 1.
5. rate_load_i with rate_i = 0 in IDLE → rate_o = 1; comb_en_o on every valid input.
6. Assert reset_i mid-RUN with a pending rate → outputs 0, rate_o = DEFAULT_RATE, pending discarded; with CIC_CTRL_STATS_EN defined, out_count_o = 0.
